// File: rtl/vga_pkg.sv
// Shared types and bus constants for the VGA pixel feeder.
package vga_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG_REQ,
      ST_CFG_WAIT,
      ST_STREAM,
      ST_PIX_WAIT,
      ST_POLL_REQ,
      ST_POLL_WAIT,
      ST_ACK_REQ,
      ST_ACK_WAIT
   } feeder_state_t;

   localparam logic [16:0] VGA_CTRL_ADDR    = 17'h10000;
   localparam logic [16:0] VGA_BUF_ADDR     = 17'h00000;
   localparam logic [31:0] CTRL_ENABLE      = 32'h001;
   localparam logic [31:0] CTRL_ACK         = 32'h021;
   localparam int          STATUS_READY_BIT = 3;

endpackage

// File: rtl/vga_raster_counter.sv
// Raster position (column/line) and per-chunk line counter.
// The wrap outputs describe what the next advance will do, so the FSM can
// pick its exit in the same cycle it requests the advance.
module vga_raster_counter #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int CHUNK_LINES = 96
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic        chunk_clear,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        h_wrap,
   output logic        frame_wrap,
   output logic        chunk_end
);

   localparam logic [10:0] H_LAST = 11'(H_RES - 1);
   localparam logic [10:0] V_LAST = 11'(V_RES - 1);
   localparam logic [10:0] C_LAST = 11'(CHUNK_LINES - 1);

   logic [10:0] chunk_cnt;

   assign h_wrap     = (hcount == H_LAST);
   assign frame_wrap = h_wrap && (vcount == V_LAST);
   assign chunk_end  = h_wrap && (chunk_cnt == C_LAST);

   // Advance column, line and chunk line counts on each completed pixel write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcount    <= '0;
         vcount    <= '0;
         chunk_cnt <= '0;
      end else begin
         if (advance) begin
            hcount <= h_wrap ? 11'd0 : hcount + 11'd1;
            if (h_wrap) begin
               vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
            end
         end
         if (chunk_clear) begin
            chunk_cnt <= '0;
         end else if (advance && h_wrap) begin
            chunk_cnt <= chunk_cnt + 11'd1;
         end
      end
   end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Streams 12-bit pixels into the VGA controller's pixel buffer over a
// single-outstanding register bus, pausing after each chunk of lines to
// poll for a free buffer and acknowledge it.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | not streaming; waits for enable_i
// CFG_REQ   | write enable word to the control register
// CFG_WAIT  | wait for the enable write to complete
// STREAM    | ready for a pixel; a handshake issues the buffer write
// PIX_WAIT  | wait for the pixel write; advance raster on completion
// POLL_REQ  | read the controller status
// POLL_WAIT | wait for status; re-poll until the buffer-ready bit is set
// ACK_REQ   | write the acknowledge word to the control register
// ACK_WAIT  | wait for the ack; stop here if the frame ended and enable is low
module vga_pixel_feeder
   import vga_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int CHUNK_LINES = 96,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic        pixel_valid_i,
   input  logic [11:0] pixel_data_i,
   output logic        pixel_ready_o,
   output logic        sof_o,
   output logic [10:0] hcount_o,
   output logic [10:0] vcount_o,
   output logic        busy_o,
   output logic        error_o,
   output logic        write_o,
   output logic [16:0] write_address_o,
   output logic [31:0] write_data_o,
   input  logic        write_done_i,
   input  logic        write_error_i,
   output logic        read_o,
   output logic [16:0] read_address_o,
   input  logic [31:0] read_data_i,
   input  logic        read_done_i,
   input  logic        read_error_i
);

   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

   feeder_state_t  state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           error_q, set_error;
   logic           advance, chunk_clear;
   logic           h_wrap, frame_wrap, chunk_end;
   logic           in_wait, timeout, at_origin;
   logic           unused_read_bits;

   // Only the buffer-ready flag of the status word matters here.
   assign unused_read_bits = ^{read_data_i[31:STATUS_READY_BIT+1], read_data_i[STATUS_READY_BIT-1:0]};

   assign in_wait   = (state == ST_CFG_WAIT) || (state == ST_PIX_WAIT) ||
                      (state == ST_POLL_WAIT) || (state == ST_ACK_WAIT);
   assign timeout   = (wait_cnt == WAIT_LIMIT);
   assign at_origin = (hcount_o == 11'd0) && (vcount_o == 11'd0);

   assign busy_o         = (state != ST_IDLE);
   assign error_o        = error_q;
   assign read_address_o = VGA_CTRL_ADDR;

   vga_raster_counter #(
      .H_RES       (H_RES),
      .V_RES       (V_RES),
      .CHUNK_LINES (CHUNK_LINES)
   ) u_raster (
      .clk         (clk_i),
      .rst_n       (rst_n_i),
      .advance     (advance),
      .chunk_clear (chunk_clear),
      .hcount      (hcount_o),
      .vcount      (vcount_o),
      .h_wrap      (h_wrap),
      .frame_wrap  (frame_wrap),
      .chunk_end   (chunk_end)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Wait-cycle counter (restarts on every request) and sticky error flag.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wait_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
         error_q  <= error_q | set_error;
      end
   end

   // Next-state and bus/stream outputs; errors take priority over done.
   always_comb begin
      state_nxt       = state;
      set_error       = 1'b0;
      advance         = 1'b0;
      chunk_clear     = 1'b0;
      write_o         = 1'b0;
      write_address_o = VGA_BUF_ADDR;
      write_data_o    = '0;
      read_o          = 1'b0;
      pixel_ready_o   = 1'b0;
      sof_o           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable_i) state_nxt = ST_CFG_REQ;
         end
         ST_CFG_REQ: begin
            write_o         = 1'b1;
            write_address_o = VGA_CTRL_ADDR;
            write_data_o    = CTRL_ENABLE;
            state_nxt       = ST_CFG_WAIT;
         end
         ST_CFG_WAIT: begin
            if (write_error_i || timeout) begin
               set_error = 1'b1;
               state_nxt = ST_IDLE;
            end else if (write_done_i) begin
               state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            pixel_ready_o = 1'b1;
            if (pixel_valid_i) begin
               write_o      = 1'b1;
               write_data_o = {20'h0, pixel_data_i};
               sof_o        = at_origin;
               state_nxt    = ST_PIX_WAIT;
            end
         end
         ST_PIX_WAIT: begin
            if (write_error_i || timeout) begin
               set_error = 1'b1;
               state_nxt = ST_IDLE;
            end else if (write_done_i) begin
               advance = 1'b1;
               if (chunk_end)                   state_nxt = ST_POLL_REQ;
               else if (frame_wrap && !enable_i) state_nxt = ST_IDLE;
               else                              state_nxt = ST_STREAM;
            end
         end
         ST_POLL_REQ: begin
            read_o    = 1'b1;
            state_nxt = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            if (read_error_i || timeout) begin
               set_error = 1'b1;
               state_nxt = ST_IDLE;
            end else if (read_done_i) begin
               state_nxt = read_data_i[STATUS_READY_BIT] ? ST_ACK_REQ : ST_POLL_REQ;
            end
         end
         ST_ACK_REQ: begin
            write_o         = 1'b1;
            write_address_o = VGA_CTRL_ADDR;
            write_data_o    = CTRL_ACK;
            state_nxt       = ST_ACK_WAIT;
         end
         ST_ACK_WAIT: begin
            if (write_error_i || timeout) begin
               set_error = 1'b1;
               state_nxt = ST_IDLE;
            end else if (write_done_i) begin
               chunk_clear = 1'b1;
               // Raster sits at the origin only when this chunk closed a frame.
               state_nxt   = (at_origin && !enable_i) ? ST_IDLE : ST_STREAM;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder on a short raster (640 x 6, 2-line chunks).
module tb_vga_pixel_feeder;

   localparam int H  = 640;
   localparam int V  = 6;
   localparam int CL = 2;
   localparam int TO = 255;

   logic        clk_i = 1'b0;
   logic        rst_n_i, enable_i, pixel_valid_i;
   logic [11:0] pixel_data_i;
   logic        pixel_ready_o, sof_o, busy_o, error_o;
   logic [10:0] hcount_o, vcount_o;
   logic        write_o, write_done_i, write_error_i;
   logic [16:0] write_address_o, read_address_o;
   logic [31:0] write_data_o, read_data_i;
   logic        read_o, read_done_i, read_error_i;

   int total = 0;
   int bad   = 0;

   // source and responder control (written by the test tasks only)
   bit src_on = 0;
   int src_limit = 0;
   bit hang = 0;
   int err_at = -1;
   int stat_base = 0;
   int stat_len = 0;
   logic [31:0] stat_seq [4];

   // monitor state (written by the posedge monitor only)
   int src_idx = 0, sof_cnt = 0, w_req = 0, r_req = 0;
   int pw_cnt = 0, cw_cnt = 0, pix_bad = 0, reads_at_ack = 0, last_pix_idx = -1;
   bit last_w_is_pix = 0;
   logic [31:0] last_cw_data = '0;
   logic [16:0] last_cw_addr = '0;

   // responder state (written by the negedge responder only)
   int w_ack = 0, r_ack = 0;

   always #5 clk_i = ~clk_i;

   vga_pixel_feeder #(.H_RES(H), .V_RES(V), .CHUNK_LINES(CL), .TIMEOUT(TO)) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .enable_i        (enable_i),
      .pixel_valid_i   (pixel_valid_i),
      .pixel_data_i    (pixel_data_i),
      .pixel_ready_o   (pixel_ready_o),
      .sof_o           (sof_o),
      .hcount_o        (hcount_o),
      .vcount_o        (vcount_o),
      .busy_o          (busy_o),
      .error_o         (error_o),
      .write_o         (write_o),
      .write_address_o (write_address_o),
      .write_data_o    (write_data_o),
      .write_done_i    (write_done_i),
      .write_error_i   (write_error_i),
      .read_o          (read_o),
      .read_address_o  (read_address_o),
      .read_data_i     (read_data_i),
      .read_done_i     (read_done_i),
      .read_error_i    (read_error_i)
   );

   function automatic logic [11:0] pix_pattern(input int i);
      return 12'(i * 37 + 5);
   endfunction

   // pixel source: valid while enabled and below the limit
   always @(negedge clk_i) begin
      pixel_valid_i = src_on && (src_idx < src_limit);
      pixel_data_i  = pix_pattern(src_idx);
   end

   // bus monitor / transaction log
   always @(posedge clk_i) begin
      if (pixel_valid_i && pixel_ready_o) src_idx <= src_idx + 1;
      if (sof_o) sof_cnt <= sof_cnt + 1;
      if (write_o) begin
         w_req <= w_req + 1;
         last_w_is_pix <= (write_address_o == 17'h0);
         if (write_address_o == 17'h0) begin
            last_pix_idx <= pw_cnt;
            pw_cnt <= pw_cnt + 1;
            if (write_data_o !== {20'h0, pix_pattern(src_idx)}) pix_bad <= pix_bad + 1;
         end else begin
            cw_cnt <= cw_cnt + 1;
            last_cw_data <= write_data_o;
            last_cw_addr <= write_address_o;
            if (write_data_o == 32'h21) reads_at_ack <= r_req;
         end
      end
      if (read_o) r_req <= r_req + 1;
   end

   // bus responder: done one cycle after each request
   always @(negedge clk_i) begin
      write_done_i  = 1'b0;
      write_error_i = 1'b0;
      read_done_i   = 1'b0;
      read_error_i  = 1'b0;
      read_data_i   = 32'h0;
      if (w_req != w_ack) begin
         w_ack = w_req;
         if (!hang) begin
            write_done_i = 1'b1;
            if (last_w_is_pix && last_pix_idx == err_at) write_error_i = 1'b1;
         end
      end
      if (r_req != r_ack) begin
         if (!hang) begin
            read_done_i = 1'b1;
            if (r_ack - stat_base < stat_len && r_ack >= stat_base) read_data_i = stat_seq[r_ack - stat_base];
            else read_data_i = 32'h8;
         end
         r_ack = r_req;
      end
   end

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0; enable_i = 1'b0; src_on = 0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; enable_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #2;
      total++; if (pixel_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", pixel_ready_o); end
      total++; if (sof_o !== 1'b0) begin bad++; $display("FAIL reset_sof got=%0h exp=0", sof_o); end
      total++; if (hcount_o !== 11'd0) begin bad++; $display("FAIL reset_hcount got=%0d exp=0", hcount_o); end
      total++; if (vcount_o !== 11'd0) begin bad++; $display("FAIL reset_vcount got=%0d exp=0", vcount_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error got=%0h exp=0", error_o); end
      total++; if (write_o !== 1'b0) begin bad++; $display("FAIL reset_write got=%0h exp=0", write_o); end
      total++; if (write_address_o !== 17'h0) begin bad++; $display("FAIL reset_waddr got=%0h exp=0", write_address_o); end
      total++; if (write_data_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", write_data_o); end
      total++; if (read_o !== 1'b0) begin bad++; $display("FAIL reset_read got=%0h exp=0", read_o); end
      total++; if (read_address_o !== 17'h10000) begin bad++; $display("FAIL reset_raddr got=%0h exp=10000", read_address_o); end
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   task automatic test_enable();
      @(negedge clk_i);
      enable_i = 1'b1;
      @(negedge clk_i); #2;
      total++; if (write_o !== 1'b1) begin bad++; $display("FAIL cfg_write got=%0h exp=1", write_o); end
      total++; if (write_address_o !== 17'h10000) begin bad++; $display("FAIL cfg_addr got=%0h exp=10000", write_address_o); end
      total++; if (write_data_o !== 32'h1) begin bad++; $display("FAIL cfg_data got=%0h exp=1", write_data_o); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL cfg_busy got=%0h exp=1", busy_o); end
      @(negedge clk_i); #2;
      total++; if (pixel_ready_o !== 1'b0) begin bad++; $display("FAIL cfg_ready_c2 got=%0h exp=0", pixel_ready_o); end
      @(negedge clk_i); #2;
      total++; if (pixel_ready_o !== 1'b1) begin bad++; $display("FAIL cfg_ready_c3 got=%0h exp=1", pixel_ready_o); end
   endtask

   task automatic test_line();
      int p0 = pw_cnt, b0 = pix_bad, c0 = cw_cnt, s0 = sof_cnt;
      bit ok = 0;
      src_limit = src_idx + H;
      src_on = 1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_i); #2;
         if (pw_cnt - p0 == H && pixel_ready_o) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL line_done got=%0d exp=%0d writes", pw_cnt - p0, H); end
      total++; if (hcount_o !== 11'd0) begin bad++; $display("FAIL line_hcount got=%0d exp=0", hcount_o); end
      total++; if (vcount_o !== 11'd1) begin bad++; $display("FAIL line_vcount got=%0d exp=1", vcount_o); end
      total++; if (pix_bad - b0 != 0) begin bad++; $display("FAIL line_data got=%0d exp=0 bad words", pix_bad - b0); end
      total++; if (cw_cnt - c0 != 0) begin bad++; $display("FAIL line_ctrl_writes got=%0d exp=0", cw_cnt - c0); end
      total++; if (sof_cnt - s0 != 1) begin bad++; $display("FAIL line_sof got=%0d exp=1", sof_cnt - s0); end
   endtask

   task automatic test_chunk();
      int p0 = pw_cnt, b0 = pix_bad, c0 = cw_cnt, r0 = r_req;
      bit ok = 0;
      stat_seq[0] = 32'h0; stat_seq[1] = 32'h0; stat_seq[2] = 32'h8;
      stat_base = r_req;
      stat_len = 3;
      src_limit = src_idx + H;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_i); #2;
         if (cw_cnt - c0 == 1 && pixel_ready_o) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL chunk_resume got=%0d exp=1 ack writes", cw_cnt - c0); end
      total++; if (r_req - r0 != 3) begin bad++; $display("FAIL chunk_reads got=%0d exp=3", r_req - r0); end
      total++; if (reads_at_ack - r0 != 3) begin bad++; $display("FAIL chunk_ack_order got=%0d exp=3", reads_at_ack - r0); end
      total++; if (last_cw_data !== 32'h21) begin bad++; $display("FAIL chunk_ack_data got=%0h exp=21", last_cw_data); end
      total++; if (last_cw_addr !== 17'h10000) begin bad++; $display("FAIL chunk_ack_addr got=%0h exp=10000", last_cw_addr); end
      total++; if (vcount_o !== 11'd2) begin bad++; $display("FAIL chunk_vcount got=%0d exp=2", vcount_o); end
      total++; if (hcount_o !== 11'd0) begin bad++; $display("FAIL chunk_hcount got=%0d exp=0", hcount_o); end
      total++; if (pw_cnt - p0 != H) begin bad++; $display("FAIL chunk_pixels got=%0d exp=%0d", pw_cnt - p0, H); end
      total++; if (pix_bad - b0 != 0) begin bad++; $display("FAIL chunk_data got=%0d exp=0 bad words", pix_bad - b0); end
      stat_len = 0;
   endtask

   task automatic test_frame_end();
      int p0 = pw_cnt, c0 = cw_cnt, r0 = r_req, s0;
      bit ok = 0;
      src_limit = src_idx + 4 * H + 10;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk_i); #2;
         if (i == 200) enable_i = 1'b0;
         if (busy_o == 1'b0) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL frame_idle got=%0h exp=0 busy", busy_o); end
      total++; if (pw_cnt - p0 != 4 * H) begin bad++; $display("FAIL frame_pixels got=%0d exp=%0d", pw_cnt - p0, 4 * H); end
      total++; if (hcount_o !== 11'd0) begin bad++; $display("FAIL frame_hcount got=%0d exp=0", hcount_o); end
      total++; if (vcount_o !== 11'd0) begin bad++; $display("FAIL frame_vcount got=%0d exp=0", vcount_o); end
      total++; if (pixel_ready_o !== 1'b0) begin bad++; $display("FAIL frame_ready got=%0h exp=0", pixel_ready_o); end
      total++; if (cw_cnt - c0 != 2) begin bad++; $display("FAIL frame_acks got=%0d exp=2", cw_cnt - c0); end
      total++; if (r_req - r0 != 2) begin bad++; $display("FAIL frame_polls got=%0d exp=2", r_req - r0); end
      total++; if (error_o !== 1'b0) begin bad++; $display("FAIL frame_error got=%0h exp=0", error_o); end
      s0 = sof_cnt;
      p0 = pw_cnt;
      ok = 0;
      enable_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i); #2;
         if (pw_cnt != p0) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL reenable_pixel got=%0d exp=1", pw_cnt - p0); end
      total++; if (sof_cnt - s0 != 1) begin bad++; $display("FAIL reenable_sof got=%0d exp=1", sof_cnt - s0); end
      total++; if (last_cw_data !== 32'h1) begin bad++; $display("FAIL reenable_cfg got=%0h exp=1", last_cw_data); end
      enable_i = 1'b0;
   endtask

   task automatic test_bus_error();
      bit ok = 0;
      do_reset();
      err_at = pw_cnt + 5;
      src_limit = src_idx + 20;
      src_on = 1;
      enable_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i); #2;
         if (error_o) begin enable_i = 1'b0; ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL err_flag got=%0h exp=1", error_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL err_busy got=%0h exp=0", busy_o); end
      total++; if (pixel_ready_o !== 1'b0) begin bad++; $display("FAIL err_ready got=%0h exp=0", pixel_ready_o); end
      total++; if (hcount_o !== 11'd5) begin bad++; $display("FAIL err_hcount got=%0d exp=5", hcount_o); end
      total++; if (vcount_o !== 11'd0) begin bad++; $display("FAIL err_vcount got=%0d exp=0", vcount_o); end
      repeat (5) @(negedge clk_i);
      #2;
      total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0h exp=1", error_o); end
      total++; if (hcount_o !== 11'd5) begin bad++; $display("FAIL err_hold got=%0d exp=5", hcount_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL err_idle got=%0h exp=0", busy_o); end
      err_at = -1;
      src_on = 0;
   endtask

   task automatic test_timeout();
      int k = 0;
      int c0;
      bit ok = 0;
      do_reset();
      hang = 1;
      c0 = cw_cnt;
      enable_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i); #2;
         if (write_o) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL to_request got=%0h exp=1", write_o); end
      ok = 0;
      for (int i = 1; i < 400; i++) begin
         @(negedge clk_i); #2;
         if (error_o) begin k = i; ok = 1; break; end
      end
      total++; if (k != TO + 2) begin bad++; $display("FAIL to_latency got=%0d exp=%0d cycles", k, TO + 2); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL to_busy got=%0h exp=0", busy_o); end
      total++; if (cw_cnt - c0 != 1) begin bad++; $display("FAIL to_single_req got=%0d exp=1", cw_cnt - c0); end
      enable_i = 1'b0;
      hang = 0;
   endtask

   initial begin
      rst_n_i = 1'b0;
      enable_i = 1'b0;
      test_reset();
      test_enable();
      test_line();
      test_chunk();
      test_frame_end();
      test_bus_error();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
